glitch_sweep_ctrl: RTL and testbench

//  Wishbone master that sequences the glitch peripheral through a 2-D parameter sweep
//  (delay inner loop, width outer loop), one glitch shot per point.
//  Per point: program WIDTH, DELAY_0/1 and MODE, trigger via STATUS, poll ready.

---
 rtl/glitch_sweep_ctrl_if.sv | 19 +
 rtl/glitch_sweep_ctrl.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_glitch_sweep_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/glitch_sweep_ctrl_if.sv
// Wishbone bus between the sweep controller (master) and the glitch
// peripheral's 8-bit slave port.
//   adr   : 4-bit register address       (master -> slave)
//   dat_w : 8-bit write data             (master -> slave)
//   dat_r : 8-bit read data              (slave  -> master)
//   we    : write enable                 (master -> slave)
//   stb   : strobe, held until ack       (master -> slave)
//   ack   : acknowledge                  (slave  -> master)
interface glitch_sweep_ctrl_if;
  logic [3:0] adr;
  logic [7:0] dat_w;
  logic [7:0] dat_r;
  logic       we;
  logic       stb;
  logic       ack;

  modport master (output adr, dat_w, we, stb, input dat_r, ack);
  modport slave  (input adr, dat_w, we, stb, output dat_r, ack);
endinterface

// File: rtl/glitch_sweep_ctrl.sv
// glitch_sweep_ctrl
// Wishbone master that walks the glitch peripheral through a 2-D sweep
// (delay inner loop, width outer loop), firing one shot per point: program
// WIDTH, DELAY_0/1 and MODE, trigger via STATUS, then poll STATUS[0] (ready).
// Optional feature macro: GLITCH_SWEEP_REPEAT_EN (adds rep_i; each point is
// fired rep_i+1 times, repeat shots go straight back to the trigger write).
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   start_i / abort_i       start pulse (latches config) / abort pulse
//   dly_first/last/step_i   16-bit delay sweep (inclusive, step 0 -> 1)
//   wid_first/last/step_i   8-bit width sweep (inclusive, step 0 -> 1)
//   mode_i                  value written to MODE for every shot
//   rep_i                   shots per point minus 1 (feature macro only)
//   wbm                     Wishbone master modport
//   busy_o, shot_o, done_o  status: in progress / shot ready / sweep done
//   err_o                   sticky poll timeout, cleared by next start
//   cur_dly_o, cur_wid_o    point of the current/last shot
module glitch_sweep_ctrl #(
  parameter int unsigned SETTLE  = 4,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  input  logic                       abort_i,
  input  logic [15:0]                dly_first_i,
  input  logic [15:0]                dly_last_i,
  input  logic [15:0]                dly_step_i,
  input  logic [7:0]                 wid_first_i,
  input  logic [7:0]                 wid_last_i,
  input  logic [7:0]                 wid_step_i,
  input  logic [7:0]                 mode_i,
`ifdef GLITCH_SWEEP_REPEAT_EN
  input  logic [3:0]                 rep_i,
`endif
  glitch_sweep_ctrl_if.master        wbm,
  output logic                       busy_o,
  output logic                       shot_o,
  output logic                       done_o,
  output logic                       err_o,
  output logic [15:0]                cur_dly_o,
  output logic [7:0]                 cur_wid_o
);

  // Glitch peripheral register map
  localparam logic [3:0] ADR_STATUS  = 4'h0;
  localparam logic [3:0] ADR_WIDTH   = 4'h1;
  localparam logic [3:0] ADR_DELAY_0 = 4'h2;
  localparam logic [3:0] ADR_DELAY_1 = 4'h3;
  localparam logic [3:0] ADR_MODE    = 4'h4;

  typedef enum logic [3:0] {
    S_IDLE, S_WR_WID, S_WR_D0, S_WR_D1, S_WR_MODE, S_TRIG, S_SETTLE, S_POLL, S_NEXT
  } state_t;

  state_t      state_q, state_d, wr_next;
  logic        stb_q, stb_d, we_q, we_d, abort_q, abort_d, err_q, err_d;
  logic        shot_q, shot_d, done_q, done_d, abort_now;
  logic [3:0]  adr_q, adr_d, wr_adr;
  logic [7:0]  dat_q, dat_d, wr_dat;
  logic [15:0] cnt_q, cnt_d, cur_dly_q, cur_dly_d;
  logic [7:0]  cur_wid_q, cur_wid_d;
  logic [15:0] dly_first_q, dly_first_d, dly_last_q, dly_last_d, dly_step_q, dly_step_d;
  logic [7:0]  wid_last_q, wid_last_d, wid_step_q, wid_step_d, mode_q, mode_d;
  logic [16:0] dsum;
  logic [8:0]  wsum;
  logic        unused_rdat;
`ifdef GLITCH_SWEEP_REPEAT_EN
  logic [3:0]  rep_q, rep_d, rep_cnt_q, rep_cnt_d;
`endif

  assign unused_rdat = ^wbm.dat_r[7:1];

  always_comb begin
    state_d     = state_q;
    stb_d       = stb_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    cnt_d       = cnt_q;
    abort_d     = abort_q;
    err_d       = err_q;
    shot_d      = 1'b0;
    done_d      = 1'b0;
    cur_dly_d   = cur_dly_q;
    cur_wid_d   = cur_wid_q;
    dly_first_d = dly_first_q;
    dly_last_d  = dly_last_q;
    dly_step_d  = dly_step_q;
    wid_last_d  = wid_last_q;
    wid_step_d  = wid_step_q;
    mode_d      = mode_q;
`ifdef GLITCH_SWEEP_REPEAT_EN
    rep_d       = rep_q;
    rep_cnt_d   = rep_cnt_q;
`endif
    abort_now   = abort_i | abort_q;
    dsum        = {1'b0, cur_dly_q} + {1'b0, dly_step_q};
    wsum        = {1'b0, cur_wid_q} + {1'b0, wid_step_q};

    wr_adr  = ADR_STATUS;
    wr_dat  = 8'h01;
    wr_next = S_SETTLE;
    case (state_q)
      S_WR_WID:  begin wr_adr = ADR_WIDTH;   wr_dat = cur_wid_q;        wr_next = S_WR_D0;   end
      S_WR_D0:   begin wr_adr = ADR_DELAY_0; wr_dat = cur_dly_q[7:0];   wr_next = S_WR_D1;   end
      S_WR_D1:   begin wr_adr = ADR_DELAY_1; wr_dat = cur_dly_q[15:8];  wr_next = S_WR_MODE; end
      S_WR_MODE: begin wr_adr = ADR_MODE;    wr_dat = mode_q;           wr_next = S_TRIG;    end
      default:   ;
    endcase

    // A bus cycle ends on the edge that samples ack; the following cycle has
    // stb low in the new state, which is the mandatory gap.
    case (state_q)
      S_IDLE: begin
        stb_d   = 1'b0;
        abort_d = 1'b0;
        if (start_i) begin
          dly_first_d = dly_first_i;
          dly_last_d  = dly_last_i;
          dly_step_d  = (dly_step_i == '0) ? 16'd1 : dly_step_i;
          wid_last_d  = wid_last_i;
          wid_step_d  = (wid_step_i == '0) ? 8'd1 : wid_step_i;
          mode_d      = mode_i;
`ifdef GLITCH_SWEEP_REPEAT_EN
          rep_d       = rep_i;
`endif
          err_d       = 1'b0;
          cur_dly_d   = dly_first_i;
          cur_wid_d   = wid_first_i;
          if (dly_first_i > dly_last_i || wid_first_i > wid_last_i) done_d = 1'b1;
          else                                                     state_d = S_WR_WID;
        end
      end
      S_WR_WID, S_WR_D0, S_WR_D1, S_WR_MODE, S_TRIG: begin
        if (stb_q) begin
          if (wbm.ack) begin
            stb_d   = 1'b0;
            cnt_d   = '0;
            state_d = abort_now ? S_IDLE : wr_next;
          end else if (abort_i) begin
            abort_d = 1'b1;
          end
        end else if (abort_i) begin
          state_d = S_IDLE;
        end else begin
          stb_d = 1'b1;
          we_d  = 1'b1;
          adr_d = wr_adr;
          dat_d = wr_dat;
        end
      end
      S_SETTLE: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == 16'(SETTLE - 1)) begin
          cnt_d   = '0;
          state_d = S_POLL;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_POLL: begin
        if (stb_q && wbm.ack) begin
          stb_d = 1'b0;
          if (abort_now) state_d = S_IDLE;
          else if (wbm.dat_r[0]) begin
            shot_d  = 1'b1;
            state_d = S_NEXT;
          end
        end else if (!stb_q && abort_i) begin
          state_d = S_IDLE;
        end else if (!stb_q) begin
          stb_d = 1'b1;
          we_d  = 1'b0;
          adr_d = ADR_STATUS;
          dat_d = '0;
        end else if (abort_i) begin
          abort_d = 1'b1;
        end
        // Timeout is measured in cycles spent in POLL, independent of how
        // the slave paces its acks; an unanswered strobe is dropped.
        if (state_d == S_POLL) begin
          if (cnt_q == 16'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            stb_d   = 1'b0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      S_NEXT: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end
`ifdef GLITCH_SWEEP_REPEAT_EN
        else if (rep_cnt_q != rep_q) begin
          rep_cnt_d = rep_cnt_q + 4'd1;
          state_d   = S_TRIG;
        end
`endif
        else if (dsum <= {1'b0, dly_last_q}) begin
          cur_dly_d = dsum[15:0];
          state_d   = S_WR_WID;
        end else if (wsum > {1'b0, wid_last_q}) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cur_dly_d = dly_first_q;
          cur_wid_d = wsum[7:0];
          state_d   = S_WR_WID;
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef GLITCH_SWEEP_REPEAT_EN
    if (state_q == S_IDLE || state_q == S_WR_WID) rep_cnt_d = '0;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      cnt_q       <= '0;
      abort_q     <= 1'b0;
      err_q       <= 1'b0;
      shot_q      <= 1'b0;
      done_q      <= 1'b0;
      cur_dly_q   <= '0;
      cur_wid_q   <= '0;
      dly_first_q <= '0;
      dly_last_q  <= '0;
      dly_step_q  <= '0;
      wid_last_q  <= '0;
      wid_step_q  <= '0;
      mode_q      <= '0;
`ifdef GLITCH_SWEEP_REPEAT_EN
      rep_q       <= '0;
      rep_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      cnt_q       <= cnt_d;
      abort_q     <= abort_d;
      err_q       <= err_d;
      shot_q      <= shot_d;
      done_q      <= done_d;
      cur_dly_q   <= cur_dly_d;
      cur_wid_q   <= cur_wid_d;
      dly_first_q <= dly_first_d;
      dly_last_q  <= dly_last_d;
      dly_step_q  <= dly_step_d;
      wid_last_q  <= wid_last_d;
      wid_step_q  <= wid_step_d;
      mode_q      <= mode_d;
`ifdef GLITCH_SWEEP_REPEAT_EN
      rep_q       <= rep_d;
      rep_cnt_q   <= rep_cnt_d;
`endif
    end
  end

  assign wbm.stb   = stb_q;
  assign wbm.we    = we_q;
  assign wbm.adr   = adr_q;
  assign wbm.dat_w = dat_q;
  assign busy_o    = (state_q != S_IDLE);
  assign shot_o    = shot_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign cur_dly_o = cur_dly_q;
  assign cur_wid_o = cur_wid_q;

endmodule

// File: tb/tb_glitch_sweep_ctrl.sv
// Self-checking bench for glitch_sweep_ctrl: a reference model expands each
// sweep into the expected bus transactions, a Wishbone slave model answers
// with programmable latency/readiness, and a monitor compares every
// completed bus cycle against the expected queue.
module tb_glitch_sweep_ctrl;
  localparam int unsigned SETTLE  = 3;
  localparam int unsigned TIMEOUT = 40;
  localparam logic [3:0] A_STATUS = 4'h0, A_WIDTH = 4'h1, A_D0 = 4'h2, A_D1 = 4'h3, A_MODE = 4'h4;

  typedef struct { logic we; logic [3:0] adr; logic [7:0] dat; } txn_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start_i = 1'b0, abort_i = 1'b0;
  logic [15:0] dly_first = '0, dly_last = '0, dly_step = '0;
  logic [7:0]  wid_first = '0, wid_last = '0, wid_step = '0, mode = '0;
`ifdef GLITCH_SWEEP_REPEAT_EN
  logic [3:0]  rep = '0;
`endif
  logic busy, shot, done, err;
  logic [15:0] cur_dly;
  logic [7:0]  cur_wid;

  int checks = 0, errors = 0;
  txn_t exp_q[$];
  // slave / monitor controls and observations
  int lat = 0, polls_needed = 1, polls = 0, wait_c = 0, hold = 0;
  bit never_ready = 0, stray_en = 0, ignore_reads = 0, err_prev = 0;
  int cyc = 0, trig_cyc = 0, err_cyc = 0, shot_cnt = 0, done_cnt = 0;

  always #5 clk = ~clk;

  glitch_sweep_ctrl_if bus ();

  glitch_sweep_ctrl #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_i), .abort_i(abort_i),
    .dly_first_i(dly_first), .dly_last_i(dly_last), .dly_step_i(dly_step),
    .wid_first_i(wid_first), .wid_last_i(wid_last), .wid_step_i(wid_step),
    .mode_i(mode),
`ifdef GLITCH_SWEEP_REPEAT_EN
    .rep_i(rep),
`endif
    .wbm(bus.master), .busy_o(busy), .shot_o(shot), .done_o(done), .err_o(err),
    .cur_dly_o(cur_dly), .cur_wid_o(cur_wid));

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, expv, $time);
    end
  endtask

  // Slave: acks after `lat` extra cycles, ready on the polls_needed-th
  // read after each trigger write, optional stray acks while stb is low.
  always @(negedge clk) begin
    bus.ack = 1'b0;
    if (!rst_n) begin
      wait_c = 0;
      bus.dat_r = '0;
    end else if (bus.stb) begin
      if (wait_c == lat) begin
        bus.ack = 1'b1;
        wait_c = 0;
        if (bus.we) begin
          if (bus.adr == A_STATUS) polls = 0;
        end else begin
          polls++;
          bus.dat_r = {7'($urandom), (!never_ready && polls >= polls_needed)};
        end
      end else begin
        wait_c++;
      end
    end else begin
      wait_c = 0;
      if (stray_en && $urandom_range(0, 1) == 1) bus.ack = 1'b1;
    end
  end

  // Monitor: a cycle with stb and ack both high completes at the next edge.
  always begin
    txn_t e;
    @(negedge clk);
    #1;
    cyc++;
    if (bus.stb) hold++;
    else hold = 0;
    if (bus.stb && bus.ack) begin
      if (bus.we || !ignore_reads) begin
        check_eq("bus_txn_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("bus_txn", {19'd0, bus.we, bus.adr, bus.we ? bus.dat_w : 8'h00},
                   {19'd0, e.we, e.adr, e.we ? e.dat : 8'h00});
        end
      end
      check_eq("stb_hold", 32'(hold), 32'(lat + 1));
      if (bus.we && bus.adr == A_STATUS) trig_cyc = cyc;
    end
    if (shot) shot_cnt++;
    if (done) done_cnt++;
    if (err && !err_prev) err_cyc = cyc;
    err_prev = err;
  end

  task automatic push_w(input logic [3:0] a, input logic [7:0] d);
    txn_t t;
    t.we = 1'b1; t.adr = a; t.dat = d;
    exp_q.push_back(t);
  endtask

  task automatic push_r();
    txn_t t;
    t.we = 1'b0; t.adr = A_STATUS; t.dat = 8'h00;
    exp_q.push_back(t);
  endtask

  // Reference: plain nested loops over the inclusive ranges.
  task automatic model(input int df, dl, ds, wf, wl, ws, md, reps,
                       output int pts, output int ld, output int lw);
    int dse, wse;
    dse = (ds == 0) ? 1 : ds;
    wse = (ws == 0) ? 1 : ws;
    pts = 0; ld = df; lw = wf;
    for (int w = wf; w <= wl; w += wse)
      for (int d = df; d <= dl; d += dse) begin
        push_w(A_WIDTH, 8'(w));
        push_w(A_D0, 8'(d));
        push_w(A_D1, 8'(d >> 8));
        push_w(A_MODE, 8'(md));
        for (int r = 0; r < reps; r++) begin
          push_w(A_STATUS, 8'h01);
          for (int p = 0; p < polls_needed; p++) push_r();
        end
        pts++; ld = d; lw = w;
      end
  endtask

  task automatic pulse_start(input logic [15:0] df, dl, ds, input logic [7:0] wf, wl, ws, md,
                             input logic [3:0] rp, input bit with_abort);
    @(posedge clk); #1;
    dly_first = df; dly_last = dl; dly_step = ds;
    wid_first = wf; wid_last = wl; wid_step = ws; mode = md;
`ifdef GLITCH_SWEEP_REPEAT_EN
    rep = rp;
`else
    if (rp != 4'd0) $display("note: repeat count ignored in this build");
`endif
    start_i = 1'b1; abort_i = with_abort;
    @(posedge clk); #1;
    start_i = 1'b0; abort_i = 1'b0;
    // Config must have been latched; scramble the live inputs.
    dly_first = 16'($urandom); dly_last = 16'($urandom); dly_step = 16'($urandom);
    wid_first = 8'($urandom); wid_last = 8'($urandom); wid_step = 8'($urandom); mode = 8'($urandom);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq(name, 32'(n < 20000), 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic sweep(input logic [15:0] df, dl, ds, input logic [7:0] wf, wl, ws, md,
                       input logic [3:0] rp, input bit with_abort);
    int pts, ld, lw, reps, s0, d0;
`ifdef GLITCH_SWEEP_REPEAT_EN
    reps = int'(rp) + 1;
`else
    reps = 1;
`endif
    exp_q.delete();
    model(int'(df), int'(dl), int'(ds), int'(wf), int'(wl), int'(ws), int'(md), reps, pts, ld, lw);
    s0 = shot_cnt; d0 = done_cnt;
    pulse_start(df, dl, ds, wf, wl, ws, md, rp, with_abort);
    check_eq("busy_after_start", 32'(busy), 32'(pts > 0));
    check_eq("err_cleared_by_start", 32'(err), 0);
    if (pts > 0) begin
      repeat (3) @(posedge clk);
      #1 start_i = 1'b1;
      @(posedge clk); #1 start_i = 1'b0;
    end
    wait_idle("sweep_completes");
    check_eq("shot_count", 32'(shot_cnt - s0), 32'(pts * reps));
    check_eq("done_count", 32'(done_cnt - d0), 1);
    check_eq("bus_queue_drained", 32'(exp_q.size()), 0);
    check_eq("err_after_sweep", 32'(err), 0);
    if (pts > 0) begin
      check_eq("cur_dly_last", 32'(cur_dly), 32'(ld));
      check_eq("cur_wid_last", 32'(cur_wid), 32'(lw));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach its end (checks %0d)", checks);
    $fatal(1);
  end

  initial begin
    int pts, ld, lw, s0, d0, n, dl_i, wl_i;
    logic [15:0] df, dl; logic [7:0] wf, wl;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outputs", {busy, shot, done, err, bus.stb, bus.we, bus.adr, bus.dat_w, cur_wid, cur_dly} , '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // abort while idle has no effect
    abort_i = 1'b1; @(posedge clk); #1 abort_i = 1'b0;
    @(posedge clk); #1;
    check_eq("abort_idle_busy", 32'(busy), 0);

    // dly 10..12, wid 5, ready after 3 polls
    lat = 0; polls_needed = 3; stray_en = 0;
    sweep(16'd10, 16'd12, 16'd1, 8'd5, 8'd5, 8'd1, 8'hA5, 4'd0, 1'b0);
    // top of delay range, no wrap past 0xFFFF
    polls_needed = 1;
    sweep(16'hFFFE, 16'hFFFF, 16'd2, 8'd1, 8'd3, 8'd2, 8'h3C, 4'd0, 1'b0);
    sweep(16'hFFFF, 16'hFFFF, 16'd1, 8'd255, 8'd255, 8'd0, 8'h11, 4'd0, 1'b0);
    // late acks plus stray acks in the gap
    lat = 3; stray_en = 1;
    sweep(16'd7, 16'd8, 16'd0, 8'd2, 8'd3, 8'd1, 8'h42, 4'd0, 1'b0);
    // empty ranges complete at once with no traffic
    lat = 0; stray_en = 0;
    sweep(16'd9, 16'd8, 16'd1, 8'd1, 8'd1, 8'd1, 8'h00, 4'd0, 1'b0);
    sweep(16'd1, 16'd2, 16'd1, 8'd4, 8'd3, 8'd1, 8'h00, 4'd0, 1'b0);
    // start and abort together: start wins
    sweep(16'd3, 16'd3, 16'd1, 8'd9, 8'd9, 8'd1, 8'h77, 4'd0, 1'b1);

    // poll timeout
    never_ready = 1; ignore_reads = 1; polls_needed = 0;
    exp_q.delete();
    model(100, 100, 1, 6, 6, 1, 8'h5A, 1, pts, ld, lw);
    s0 = shot_cnt; d0 = done_cnt;
    pulse_start(16'd100, 16'd100, 16'd1, 8'd6, 8'd6, 8'd1, 8'h5A, 4'd0, 1'b0);
    wait_idle("timeout_terminates");
    check_eq("timeout_err", 32'(err), 1);
    check_eq("timeout_no_done", 32'(done_cnt - d0), 0);
    check_eq("timeout_no_shot", 32'(shot_cnt - s0), 0);
    check_eq("timeout_writes", 32'(exp_q.size()), 0);
    // trigger completes on the edge after its ack sample, then SETTLE idle
    // cycles and TIMEOUT poll cycles before err_o is registered
    check_eq("timeout_cycles", 32'(err_cyc - trig_cyc), 32'(SETTLE + TIMEOUT + 1));

    // reset in the middle of a poll read drops stb immediately
    lat = 2;
    exp_q.delete();
    model(1, 1, 1, 1, 1, 1, 8'h01, 1, pts, ld, lw);
    pulse_start(16'd1, 16'd1, 16'd1, 8'd1, 8'd1, 8'd1, 8'h01, 4'd0, 1'b0);
    check_eq("err_sticky_cleared", 32'(err), 0);
    n = 0;
    while (!(bus.stb && !bus.we) && n < 500) begin @(posedge clk); #1; n++; end
    check_eq("poll_reached", 32'(n < 500), 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("reset_mid_poll_stb", 32'(bus.stb), 0);
    check_eq("reset_mid_poll_busy", 32'(busy), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    exp_q.delete();
    never_ready = 0; ignore_reads = 0; polls_needed = 1;

    // abort during the DELAY_1 write
    exp_q.delete();
    model(10, 12, 1, 5, 5, 1, 8'hA5, 1, pts, ld, lw);
    while (exp_q.size() > 3) void'(exp_q.pop_back());
    s0 = shot_cnt; d0 = done_cnt;
    pulse_start(16'd10, 16'd12, 16'd1, 8'd5, 8'd5, 8'd1, 8'hA5, 4'd0, 1'b0);
    n = 0;
    while (!(bus.stb && bus.adr == A_D1) && n < 500) begin @(posedge clk); #1; n++; end
    check_eq("d1_reached", 32'(n < 500), 1);
    abort_i = 1'b1; @(posedge clk); #1 abort_i = 1'b0;
    wait_idle("abort_terminates");
    check_eq("abort_writes", 32'(exp_q.size()), 0);
    check_eq("abort_no_done", 32'(done_cnt - d0), 0);
    check_eq("abort_no_shot", 32'(shot_cnt - s0), 0);
    check_eq("abort_cur_dly", 32'(cur_dly), 32'd10);
    check_eq("abort_cur_wid", 32'(cur_wid), 32'd5);
    check_eq("abort_err", 32'(err), 0);

`ifdef GLITCH_SWEEP_REPEAT_EN
    sweep(16'd20, 16'd20, 16'd1, 8'd4, 8'd4, 8'd1, 8'h99, 4'd2, 1'b0);
`endif

    // randomized sweeps
    for (int i = 0; i < 10; i++) begin
      lat = $urandom_range(0, 3);
      polls_needed = $urandom_range(1, 3);
      stray_en = ($urandom_range(0, 1) == 1);
      df = ($urandom_range(0, 3) == 0) ? 16'(16'hFFF8 + $urandom_range(0, 7)) : 16'($urandom_range(0, 50));
      dl_i = int'(df) + $urandom_range(0, 6);
      dl = (dl_i > 65535) ? 16'hFFFF : 16'(dl_i);
      wf = 8'($urandom_range(0, 255));
      wl_i = int'(wf) + $urandom_range(0, 2);
      wl = (wl_i > 255) ? 8'hFF : 8'(wl_i);
      if ($urandom_range(0, 7) == 0) wl = wf - 8'd1;
      sweep(df, dl, 16'($urandom_range(0, 3)), wf, wl, 8'($urandom_range(0, 2)),
            8'($urandom), 4'($urandom_range(0, 2)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
